// File: rtl/adc_rx.sv
// Serial ADC reader: frames cs/sck, shifts in a 16-bit MSB-first word on sck rising edges,
// and presents it as a parallel word with a one-cycle valid strobe.
module adc_rx #(
    parameter int SCK_DIV = 2,
    parameter int T_CSS   = 2,
    parameter int T_QUIET = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_state,
    input  logic        en_adc,
    input  logic        sdo,
    output logic        cs,
    output logic        sck,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic        busy
);

    localparam int TMAX = (T_CSS > T_QUIET) ? T_CSS : T_QUIET;
    localparam int CW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int DW   = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;

    localparam logic [CW-1:0] CSS_LAST   = CW'(T_CSS - 1);
    localparam logic [CW-1:0] QUIET_LAST = CW'(T_QUIET - 1);
    localparam logic [DW-1:0] DIV_LAST   = DW'(SCK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_QUIET
    } state_t;

    state_t        state, nxt_state;
    logic [CW-1:0] cnt, nxt_cnt;
    logic [DW-1:0] div_cnt, nxt_div_cnt;
    logic [4:0]    edge_cnt, nxt_edge_cnt;
    logic [15:0]   shreg, nxt_shreg;
    logic          nxt_cs, nxt_sck, nxt_data_valid, nxt_busy;
    logic [15:0]   nxt_data_out;

    always_ff @(posedge clk) begin
        if (!rst_n || !key_state) begin
            state      <= S_IDLE;
            cnt        <= '0;
            div_cnt    <= '0;
            edge_cnt   <= '0;
            shreg      <= '0;
            cs         <= 1'b1;
            sck        <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= nxt_state;
            cnt        <= nxt_cnt;
            div_cnt    <= nxt_div_cnt;
            edge_cnt   <= nxt_edge_cnt;
            shreg      <= nxt_shreg;
            cs         <= nxt_cs;
            sck        <= nxt_sck;
            data_out   <= nxt_data_out;
            data_valid <= nxt_data_valid;
            busy       <= nxt_busy;
        end
    end

    always_comb begin
        nxt_state      = state;
        nxt_cnt        = cnt;
        nxt_div_cnt    = div_cnt;
        nxt_edge_cnt   = edge_cnt;
        nxt_shreg      = shreg;
        nxt_cs         = cs;
        nxt_sck        = sck;
        nxt_data_out   = data_out;
        nxt_data_valid = 1'b0;

        case (state)
            S_IDLE: begin
                nxt_cs  = 1'b1;
                nxt_sck = 1'b0;
                if (en_adc) begin
                    nxt_state    = S_SETUP;
                    nxt_cs       = 1'b0;
                    nxt_cnt      = '0;
                    nxt_div_cnt  = '0;
                    nxt_edge_cnt = '0;
                end
            end
            S_SETUP: begin
                if (cnt == CSS_LAST) begin
                    nxt_state   = S_SHIFT;
                    nxt_cnt     = '0;
                    nxt_div_cnt = '0;
                end else begin
                    nxt_cnt = cnt + 1'b1;
                end
            end
            S_SHIFT: begin
                if (div_cnt == DIV_LAST) begin
                    nxt_div_cnt = '0;
                    if (!sck) begin
                        // Data is captured on the same edge that drives sck high.
                        nxt_sck      = 1'b1;
                        nxt_shreg    = {shreg[14:0], sdo};
                        nxt_edge_cnt = edge_cnt + 5'd1;
                    end else if (edge_cnt == 5'd16) begin
                        nxt_sck        = 1'b0;
                        nxt_cs         = 1'b1;
                        nxt_data_out   = shreg;
                        nxt_data_valid = 1'b1;
                        nxt_state      = S_QUIET;
                        nxt_cnt        = '0;
                    end else begin
                        nxt_sck = 1'b0;
                    end
                end else begin
                    nxt_div_cnt = div_cnt + 1'b1;
                end
            end
            S_QUIET: begin
                nxt_cs = 1'b1;
                if (cnt == QUIET_LAST) begin
                    nxt_state = S_IDLE;
                    nxt_cnt   = '0;
                end else begin
                    nxt_cnt = cnt + 1'b1;
                end
            end
            default: begin
                nxt_state = S_IDLE;
                nxt_cs    = 1'b1;
                nxt_sck   = 1'b0;
            end
        endcase

        nxt_busy = (nxt_state != S_IDLE);
    end

endmodule

// File: tb/tb_adc_rx.sv
// Bench for adc_rx: default-timing instance plus a fastest-timing instance, each driven
// by a behavioural ADC that shifts a word out on sck falling edges.
module tb_adc_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_state;

    logic        en_adc, sdo, cs, sck, data_valid, busy;
    logic [15:0] data_out;
    logic        f_en_adc, f_sdo, f_cs, f_sck, f_data_valid, f_busy;
    logic [15:0] f_data_out;

    adc_rx dut (
        .clk(clk), .rst_n(rst_n), .key_state(key_state), .en_adc(en_adc), .sdo(sdo),
        .cs(cs), .sck(sck), .data_out(data_out), .data_valid(data_valid), .busy(busy)
    );

    adc_rx #(.SCK_DIV(1), .T_CSS(1), .T_QUIET(1)) dut_f (
        .clk(clk), .rst_n(rst_n), .key_state(key_state), .en_adc(f_en_adc), .sdo(f_sdo),
        .cs(f_cs), .sck(f_sck), .data_out(f_data_out), .data_valid(f_data_valid), .busy(f_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ADC models: word latched at cs fall, next bit presented on each sck fall
    logic [15:0] adc_word = '0, adc_sh = '0, f_adc_word = '0, f_adc_sh = '0;
    int bitn = -1, f_bitn = -1;

    initial begin sdo = 1'b0; f_sdo = 1'b0; end

    always @(negedge cs) begin adc_sh = adc_word; sdo = adc_sh[15]; bitn = 14; end
    always @(negedge sck) if (!cs && bitn >= 0) begin sdo = adc_sh[bitn]; bitn--; end
    always @(negedge f_cs) begin f_adc_sh = f_adc_word; f_sdo = f_adc_sh[15]; f_bitn = 14; end
    always @(negedge f_sck) if (!f_cs && f_bitn >= 0) begin f_sdo = f_adc_sh[f_bitn]; f_bitn--; end

    int sck_rises = 0;
    always @(posedge sck) sck_rises++;

    // Scoreboards
    logic [15:0] q[$];
    logic [15:0] fq[$];
    int dv_total = 0;

    always @(negedge clk) begin
        if (data_valid) begin
            dv_total++;
            if (q.size() == 0) check("dv_unexpected", {31'd0, data_valid}, 32'd0);
            else check("data", {16'd0, data_out}, {16'd0, q.pop_front()});
        end
        if (f_data_valid) begin
            if (fq.size() == 0) check("f_dv_unexpected", {31'd0, f_data_valid}, 32'd0);
            else check("f_data", {16'd0, f_data_out}, {16'd0, fq.pop_front()});
        end
    end

    task automatic start_frame(input logic [15:0] w, input bit expect_out);
        adc_word = w;
        if (expect_out) q.push_back(w);
        en_adc = 1'b1;
        tick;
        en_adc = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && busy; i++) tick;
        check("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cs_last, dv_e, dv_n, busy_fall, dv_before;
        rst_n = 1'b0; key_state = 1'b1; en_adc = 1'b0; f_en_adc = 1'b0;
        tick; tick;
        check("rst_cs", {31'd0, cs}, 32'd1);
        check("rst_sck", {31'd0, sck}, 32'd0);
        check("rst_data", {16'd0, data_out}, 32'd0);
        check("rst_dv", {31'd0, data_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        tick;

        // Single frame with default timing
        sck_rises = 0;
        start_frame(16'hA5C3, 1'b1);
        check("a_cs_e0", {31'd0, cs}, 32'd0);
        check("a_busy_e0", {31'd0, busy}, 32'd1);
        cs_last = -1; dv_e = -1; dv_n = 0; busy_fall = -1;
        for (int e = 1; e <= 75; e++) begin
            tick;
            if (!cs) cs_last = e;
            if (data_valid) begin dv_n++; dv_e = e; end
            if (!busy && busy_fall < 0) busy_fall = e;
            if (e == 2) check("a_sck_at_tcss", {31'd0, sck}, 32'd0);
        end
        check("a_cs_last_low", cs_last, 65);
        check("a_dv_edge", dv_e, 66);
        check("a_dv_count", dv_n, 1);
        check("a_busy_fall", busy_fall, 70);
        check("a_sck_rises", sck_rises, 16);

        // Back-to-back: starts at edges 30 and 70 ignored, 71 accepted
        start_frame(16'h1234, 1'b1);
        dv_e = -1;
        for (int e = 1; e <= 71; e++) begin
            en_adc = (e == 30 || e == 70 || e == 71);
            if (e == 71) q.push_back(16'h5A3C);
            tick;
            if (data_valid) dv_e = e;
            if (e == 30) check("b_cs_e30", {31'd0, cs}, 32'd0);
            if (e == 68) adc_word = 16'h5A3C;
            if (e == 70) begin
                check("b_busy_e70", {31'd0, busy}, 32'd0);
                check("b_cs_e70", {31'd0, cs}, 32'd1);
            end
            if (e == 71) begin
                check("b_cs_e71", {31'd0, cs}, 32'd0);
                check("b_busy_e71", {31'd0, busy}, 32'd1);
            end
        end
        en_adc = 1'b0;
        check("b_dv_edge", dv_e, 66);
        wait_idle(120);

        // key_state drop mid-SHIFT aborts the frame
        start_frame(16'hBEEF, 1'b0);
        dv_before = dv_total;
        for (int e = 1; e <= 39; e++) tick;
        key_state = 1'b0;
        tick;
        check("k_cs", {31'd0, cs}, 32'd1);
        check("k_sck", {31'd0, sck}, 32'd0);
        check("k_data", {16'd0, data_out}, 32'd0);
        check("k_busy", {31'd0, busy}, 32'd0);
        key_state = 1'b1;
        for (int i = 0; i < 80; i++) tick;
        check("k_no_dv", dv_total, dv_before);

        // rst_n during QUIET, then a normal frame
        start_frame(16'h0F0F, 1'b1);
        for (int e = 1; e <= 68; e++) tick;
        rst_n = 1'b0;
        tick;
        check("r_cs", {31'd0, cs}, 32'd1);
        check("r_sck", {31'd0, sck}, 32'd0);
        check("r_data", {16'd0, data_out}, 32'd0);
        check("r_dv", {31'd0, data_valid}, 32'd0);
        check("r_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        tick;
        start_frame(16'hC001, 1'b1);
        wait_idle(100);

        // Fastest timing instance
        foreach (fq[i]) fq.delete(i);
        for (int k = 0; k < 3; k++) begin
            logic [15:0] w;
            w = (k == 0) ? 16'h0000 : (k == 1) ? 16'hFFFF : 16'h8001;
            f_adc_word = w;
            fq.push_back(w);
            f_en_adc = 1'b1;
            tick;
            f_en_adc = 1'b0;
            dv_e = -1;
            for (int e = 1; e <= 36; e++) begin
                tick;
                if (f_data_valid) dv_e = e;
            end
            check("f_dv_edge", dv_e, 33);
            check("f_idle", {31'd0, f_busy}, 32'd0);
        end

        check("q_empty", q.size(), 0);
        check("fq_empty", fq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
